// File: rtl/syn_pipe_stage_elastic.sv
// rtl/syn_pipe_stage_elastic.sv - elastic inter-stage register with valid/ready, optional skid entry, flush and stall counter
module syn_pipe_stage_elastic #(
  parameter int                DATA_W     = 32,
  parameter int                SKID       = 1,
  parameter int                CLEAR_DATA = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_main_v;
  logic [DATA_W-1:0] r_main_d;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_skid_v;
  logic              w_fire_in;
  logic              w_fire_out;

  assign w_fire_in  = in_valid & in_ready;
  assign w_fire_out = r_main_v & out_ready;

  assign out_valid  = r_main_v;
  assign out_data   = r_main_d;
  assign occupancy  = {1'b0, r_main_v} + {1'b0, w_skid_v};
  assign stall_cnt  = r_stall_cnt;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_skid_v;
      logic [DATA_W-1:0] r_skid_d;

      // in_ready comes straight from a flop, so downstream ready never reaches upstream
      assign in_ready = ~r_skid_v;
      assign w_skid_v = r_skid_v;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
          r_main_d <= CLEAR_VAL;
          r_skid_d <= CLEAR_VAL;
        end else if (flush) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
          if (CLEAR_DATA != 0) begin
            r_main_d <= CLEAR_VAL;
            r_skid_d <= CLEAR_VAL;
          end
        end else if (r_skid_v) begin
          if (w_fire_out) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end else if (r_main_v) begin
          if (w_fire_in && w_fire_out) begin
            r_main_d <= in_data;
          end else if (w_fire_out) begin
            r_main_v <= 1'b0;
          end else if (w_fire_in) begin
            r_skid_d <= in_data;
            r_skid_v <= 1'b1;
          end
        end else if (w_fire_in) begin
          r_main_d <= in_data;
          r_main_v <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~r_main_v | out_ready;
      assign w_skid_v = 1'b0;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_main_v <= 1'b0;
          r_main_d <= CLEAR_VAL;
        end else if (flush) begin
          r_main_v <= 1'b0;
          if (CLEAR_DATA != 0) begin
            r_main_d <= CLEAR_VAL;
          end
        end else if (w_fire_in) begin
          r_main_d <= in_data;
          r_main_v <= 1'b1;
        end else if (w_fire_out) begin
          r_main_v <= 1'b0;
        end
      end
    end
  endgenerate

  // Flush does not clear the counter; it still counts a stalled flush cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_main_v && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_syn_pipe_stage_elastic.sv
// tb/tb_syn_pipe_stage_elastic.sv - scoreboard bench for syn_pipe_stage_elastic (skid and no-skid builds)
module tb_syn_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: SKID=1, CLEAR_DATA=1, CLEAR_VAL=0, CNT_W=16
  logic        a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data, a_stall;
  logic [1:0]  a_occ;
  // B: SKID=0, CLEAR_DATA=0, CLEAR_VAL=0x00C3, CNT_W=4
  logic        b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [3:0]  b_stall;
  logic [1:0]  b_occ;

  syn_pipe_stage_elastic #(.DATA_W(16), .SKID(1), .CLEAR_DATA(1), .CLEAR_VAL(16'h0000), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  syn_pipe_stage_elastic #(.DATA_W(16), .SKID(0), .CLEAR_DATA(0), .CLEAR_VAL(16'h00C3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] a_q[$];
  logic [15:0] b_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Scoreboard is evaluated mid-cycle, when inputs and outputs are settled for the next edge
  task automatic tick();
    @(negedge clk);
    if (!a_rst_n || a_flush) a_q.delete();
    else begin
      if (a_out_valid && a_out_ready) begin
        check("a_sb_nonempty", 32'(a_q.size() != 0), 32'd1);
        if (a_q.size() != 0) check("a_sb_data", 32'(a_out_data), 32'(a_q.pop_front()));
      end
      if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
    end
    if (!b_rst_n || b_flush) b_q.delete();
    else begin
      if (b_out_valid && b_out_ready) begin
        check("b_sb_nonempty", 32'(b_q.size() != 0), 32'd1);
        if (b_q.size() != 0) check("b_sb_data", 32'(b_out_data), 32'(b_q.pop_front()));
      end
      if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [15:0] d, input logic rdy);
    a_in_valid = v; a_in_data = d; a_out_ready = rdy;
  endtask

  task automatic b_drive(input logic v, input logic [15:0] d, input logic rdy);
    b_in_valid = v; b_in_data = d; b_out_ready = rdy;
  endtask

  initial begin
    logic [15:0] seq1 [3];
    seq1[0] = 16'h0011; seq1[1] = 16'h0022; seq1[2] = 16'h0033;
    a_rst_n = 1'b0; a_flush = 1'b0; a_drive(1'b0, 16'h0, 1'b0);
    b_rst_n = 1'b0; b_flush = 1'b0; b_drive(1'b0, 16'h0, 1'b0);
    tick(); tick();

    check("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("a_rst_occ",       32'(a_occ),       32'd0);
    check("a_rst_out_data",  32'(a_out_data),  32'h0);
    check("a_rst_in_ready",  32'(a_in_ready),  32'd1);
    check("a_rst_stall",     32'(a_stall),     32'd0);
    check("b_rst_out_data",  32'(b_out_data),  32'h00C3);
    check("b_rst_in_ready",  32'(b_in_ready),  32'd1);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // streaming with out_ready held high
    for (int i = 0; i < 3; i++) begin
      a_drive(1'b1, seq1[i], 1'b1);
      tick();
      check("t1_out_data", 32'(a_out_data), 32'(seq1[i]));
      check("t1_occ",      32'(a_occ),      32'd1);
      check("t1_in_ready", 32'(a_in_ready), 32'd1);
    end
    a_drive(1'b0, 16'h0, 1'b1);
    tick();
    check("t1_occ_drained", 32'(a_occ),   32'd0);
    check("t1_stall",       32'(a_stall), 32'd0);

    // fill main and skid under backpressure
    a_drive(1'b1, 16'h00A0, 1'b0); tick();
    check("t2_in_ready_1", 32'(a_in_ready), 32'd1);
    a_drive(1'b1, 16'h00A1, 1'b0); tick();
    check("t2_in_ready_0", 32'(a_in_ready), 32'd0);
    check("t2_occ_full",   32'(a_occ),      32'd2);
    a_drive(1'b1, 16'h00A2, 1'b0); tick();
    check("t2_occ_hold",   32'(a_occ),      32'd2);
    check("t2_data_hold",  32'(a_out_data), 32'h00A0);
    check("t2_stall",      32'(a_stall),    32'd2);
    a_drive(1'b1, 16'h00A2, 1'b1); tick();
    check("t2_main_from_skid", 32'(a_out_data), 32'h00A1);
    check("t2_in_ready_back",  32'(a_in_ready), 32'd1);
    tick();
    check("t2_last", 32'(a_out_data), 32'h00A2);
    a_drive(1'b0, 16'h0, 1'b1); tick();
    check("t2_occ_empty", 32'(a_occ), 32'd0);

    // flush while full, with a pending input
    a_drive(1'b1, 16'h00B0, 1'b0); tick();
    a_drive(1'b1, 16'h00B1, 1'b0); tick();
    check("t3_occ_full", 32'(a_occ), 32'd2);
    a_drive(1'b1, 16'hBEEF, 1'b0); a_flush = 1'b1; tick();
    a_flush = 1'b0;
    check("t3_out_valid", 32'(a_out_valid), 32'd0);
    check("t3_occ",       32'(a_occ),       32'd0);
    check("t3_out_data",  32'(a_out_data),  32'h0);
    check("t3_stall",     32'(a_stall),     32'd4);
    // flush while the input actually handshakes
    a_drive(1'b1, 16'h00C0, 1'b0); tick();
    a_drive(1'b1, 16'hBEEF, 1'b0); a_flush = 1'b1; tick();
    a_flush = 1'b0;
    check("t3b_occ",   32'(a_occ),   32'd0);
    check("t3b_stall", 32'(a_stall), 32'd5);
    a_drive(1'b0, 16'h0, 1'b1); tick();
    check("t3b_no_beef", 32'(a_out_valid), 32'd0);

    // reset mid-stream with both entries held
    a_drive(1'b1, 16'h00D0, 1'b0); tick();
    a_drive(1'b1, 16'h00D1, 1'b0); tick();
    check("t4_stall_pre", 32'(a_stall), 32'd6);
    a_drive(1'b1, 16'h0077, 1'b0); a_rst_n = 1'b0; tick();
    check("t4_occ",       32'(a_occ),       32'd0);
    check("t4_out_valid", 32'(a_out_valid), 32'd0);
    check("t4_stall",     32'(a_stall),     32'd0);
    check("t4_in_ready",  32'(a_in_ready),  32'd1);
    a_rst_n = 1'b1; a_drive(1'b1, 16'h0055, 1'b1); tick();
    check("t4_accept", 32'(a_out_data), 32'h0055);
    check("t4_occ1",   32'(a_occ),      32'd1);
    a_drive(1'b0, 16'h0, 1'b1); tick();

    // no-skid build: combinational in_ready
    b_drive(1'b1, 16'h0010, 1'b0); tick();
    check("t6_in_ready_stall", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1; #1;
    check("t6_in_ready_comb", 32'(b_in_ready), 32'd1);
    b_drive(1'b1, 16'h0020, 1'b1); tick();
    check("t6_b2b_1", 32'(b_out_data), 32'h0020);
    check("t6_occ",   32'(b_occ),      32'd1);
    b_drive(1'b1, 16'h0030, 1'b1); tick();
    check("t6_b2b_2", 32'(b_out_data), 32'h0030);

    // saturating stall counter (4 bits)
    b_drive(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) check("t5_stall_10", 32'(b_stall), 32'd10);
    end
    check("t5_stall_sat",  32'(b_stall),    32'd15);
    check("t5_data_held",  32'(b_out_data), 32'h0030);
    b_drive(1'b1, 16'hBEEF, 1'b0); b_flush = 1'b1; tick();
    check("t5_stall_flush",   32'(b_stall),     32'd15);
    check("t3c_out_valid",    32'(b_out_valid), 32'd0);
    check("t3c_data_kept",    32'(b_out_data),  32'h0030);
    tick();
    check("t3c_flush_accept", 32'(b_out_valid), 32'd0);
    check("t3c_data_kept2",   32'(b_out_data),  32'h0030);
    b_flush = 1'b0; b_drive(1'b0, 16'h0, 1'b1); tick();
    check("t3c_no_beef", 32'(b_out_valid), 32'd0);

    check("a_sb_drained", 32'(a_q.size()), 32'd0);
    check("b_sb_drained", 32'(b_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
